mux_sel_sequencer: RTL and testbench
====================================

// Module: mux_sel_sequencer
// PURPOSE
//  Owns the select line of the 2:1 mux (sel=0 -> a0 path, sel=1 -> dataA&dataB path).
//  Shares the mux output between two requesters with round-robin arbitration.
//  Blanks the output for a settle window whenever sel changes, so no downstream
//  consumer ever samples a select-switch glitch. Sits directly in front of the mux.
// PARAMETERS
//  SETTLE_CYC  2  blanking cycles after every sel change (legal >=1)
//  MAX_HOLD    8  max GRANT cycles while the other requester waits (legal >=1)
// PORTS
//  clk     in   1  single clock, rising edge
//  rst_n   in   1  asynchronous reset, active-low
//  req0    in   1  requester 0 wants the a0 path (level, held until done)
//  req1    in   1  requester 1 wants the dataA&dataB path (level)
//  sel     out  1  mux select, registered
//  out_en  out  1  mux output valid/unblanked; equals gnt0|gnt1
//  gnt0    out  1  grant to requester 0, registered
//  gnt1    out  1  grant to requester 1, registered
//  busy    out  1  state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE, sel=0, gnt0=gnt1=0, out_en=0, busy=0,
//   last_gnt=1 (first tie goes to req0), counters=0. Any cycle, incl. mid-grant.
//  States: IDLE, SETTLE, GRANT. Internal: tgt (granted/target index), cnt.
//  IDLE: no req -> stay. Else tgt = sole requester; both -> tgt = !last_gnt.
//   tgt==sel -> GRANT next edge (gnt visible cycle N+1 for req seen in cycle N).
//   tgt!=sel -> SETTLE next edge; sel<=tgt on that edge; cnt<=0.
//  SETTLE: out_en=0, gnts=0; cnt increments each cycle; after SETTLE_CYC cycles:
//   req[tgt] still high -> GRANT; else -> IDLE (sel keeps new value).
//   Mismatch latency: req in cycle N -> sel flips N+1 -> gnt at N+1+SETTLE_CYC.
//  GRANT: gnt[tgt]=1, out_en=1, last_gnt<=tgt on entry; cnt cleared on entry.
//   cnt increments only while req[!tgt] high; saturates at MAX_HOLD-1.
//   req[tgt] low -> IDLE next edge (gnt drops next cycle; other req then
//    served via IDLE rules, one idle cycle of arbitration).
//   req[tgt] high, req[!tgt] high, cnt==MAX_HOLD-1 -> preempt: gnt drops,
//    sel<=!tgt, tgt<=!tgt, SETTLE.
//   req[tgt] low same cycle as preempt condition -> release wins (IDLE).
//  Invariants: sel never changes while out_en=1; gnt0&gnt1 never both 1;
//   every sel edge followed by >=SETTLE_CYC cycles of out_en=0.
//  Counter width derived locally from max(SETTLE_CYC,MAX_HOLD); no wrap.
// TESTING
//  Reset then req0=1 from cycle 1 -> gnt0=1,out_en=1,sel=0 in cycle 2; no blanking.
//  After reset, req1=1 cycle 1 -> sel=1 cycle 2, out_en=0 cycles 2-3, gnt1 cycle 4.
//  req0,req1 both high from reset, MAX_HOLD=8 -> gnt0 8 cycles, 2 blank, gnt1 8...
//   alternating forever; check sel stable whenever out_en=1.
//  gnt1 active, drop req1 for 1 cycle during SETTLE toward sel=0 (req0 also dropped)
//   -> SETTLE completes, IDLE, sel stays 0, no gnt.
//  rst_n low mid-GRANT(sel=1) -> same cycle: gnt/out_en=0, sel=0, busy=0.
//  req0 release coinciding with preempt point -> IDLE then req1 served via settle.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// Round-robin owner of a 2:1 mux select; blanks the mux output for SETTLE_CYC cycles after every select change.
// Latency: grant 1 cycle after request if sel already matches, else 1+SETTLE_CYC; requesters are level-held and simply wait.
module mux_sel_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int MAX_HOLD   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic sel,
  output logic out_en,
  output logic gnt0,
  output logic gnt1,
  output logic busy
);

  localparam int CMAX = (SETTLE_CYC > MAX_HOLD) ? SETTLE_CYC : MAX_HOLD;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic          sel_d;
  logic          tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_gnt, last_d;
  logic          gnt0_d, gnt1_d;
  logic          pick_tgt, req_tgt, req_oth;

  // A tie goes to whoever was not granted last.
  assign pick_tgt = (req0 && req1) ? ~last_gnt : req1;
  assign req_tgt  = tgt_q ? req1 : req0;
  assign req_oth  = tgt_q ? req0 : req1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    last_d  = last_gnt;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          tgt_d = pick_tgt;
          cnt_d = '0;
          if (pick_tgt == sel) begin
            state_d = GRANT;
            last_d  = pick_tgt;
          end else begin
            state_d = SETTLE;
            sel_d   = pick_tgt;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (req_tgt) begin
            state_d = GRANT;
            last_d  = tgt_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GRANT: begin
        // Release is checked first so it beats a simultaneous preempt.
        if (!req_tgt) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (req_oth) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = SETTLE;
            sel_d   = ~tgt_q;
            tgt_d   = ~tgt_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0_d = (state_d == GRANT) && !tgt_d;
  assign gnt1_d = (state_d == GRANT) &&  tgt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel      <= 1'b0;
      tgt_q    <= 1'b0;
      cnt_q    <= '0;
      last_gnt <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel      <= sel_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      last_gnt <= last_d;
      gnt0     <= gnt0_d;
      gnt1     <= gnt1_d;
    end
  end

  assign out_en = gnt0 | gnt1;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: directed scenarios plus random request traffic against an owner/blank-countdown model.
// Outputs are sampled 1 time unit after each rising edge; inputs change only after sampling.
module tb_mux_sel_sequencer;

  localparam int SETTLE_CYC = 2;
  localparam int MAX_HOLD   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic sel, out_en, gnt0, gnt1, busy;

  int checks = 0;
  int errors = 0;

  // Model: who owns the mux (-1 none), blanking cycles left, pending target, waiting cycles.
  int m_owner, m_bl, m_pend, m_waited, m_sel, m_last;

  mux_sel_sequencer #(.SETTLE_CYC(SETTLE_CYC), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .sel(sel), .out_en(out_en), .gnt0(gnt0), .gnt1(gnt1), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1; m_bl = 0; m_pend = 0; m_waited = 0; m_sel = 0; m_last = 1;
  endfunction

  function automatic void model_step(input bit r0, input bit r1);
    bit r [2];
    int t;
    r[0] = r0; r[1] = r1;
    if (m_owner >= 0) begin
      if (!r[m_owner]) m_owner = -1;
      else if (r[1-m_owner]) begin
        m_waited++;
        if (m_waited >= MAX_HOLD) begin
          m_pend = 1 - m_owner; m_sel = m_pend; m_bl = SETTLE_CYC; m_owner = -1;
        end
      end
    end else if (m_bl > 0) begin
      m_bl--;
      if (m_bl == 0 && r[m_pend]) begin
        m_owner = m_pend; m_last = m_pend; m_waited = 0;
      end
    end else if (r0 || r1) begin
      t = (r0 && r1) ? (1 - m_last) : (r1 ? 1 : 0);
      if (t == m_sel) begin
        m_owner = t; m_last = t; m_waited = 0;
      end else begin
        m_sel = t; m_pend = t; m_bl = SETTLE_CYC;
      end
    end
  endfunction

  // {sel, out_en, gnt0, gnt1, busy}
  function automatic logic [4:0] mexp();
    logic [4:0] v;
    v[4] = (m_sel == 1);
    v[3] = (m_owner >= 0);
    v[2] = (m_owner == 0);
    v[1] = (m_owner == 1);
    v[0] = (m_owner >= 0) || (m_bl > 0);
    return v;
  endfunction

  function automatic logic [4:0] obs();
    return {sel, out_en, gnt0, gnt1, busy};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step(req0, req1);
    #1;
  endtask

  task automatic apply_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 5'b00000) begin
      errors++; $display("FAIL reset_async got=%b want=%b", obs(), 5'b00000);
    end
    apply_reset();
    step();
    checks++;
    if (obs() !== mexp() || obs() !== 5'b00000) begin
      errors++; $display("FAIL reset_idle got=%b want=%b", obs(), mexp());
    end
  endtask

  task automatic test_direct_grant();
    apply_reset();
    req0 = 1'b1;
    step();
    checks++;
    if (obs() !== 5'b01101 || obs() !== mexp()) begin
      errors++; $display("FAIL direct_grant_first got=%b want=%b", obs(), 5'b01101);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs() !== mexp()) begin
        errors++; $display("FAIL direct_grant_hold cyc=%0d got=%b want=%b", i, obs(), mexp());
      end
    end
    req0 = 1'b0;
    step();
    checks++;
    if (obs() !== 5'b00000 || obs() !== mexp()) begin
      errors++; $display("FAIL direct_grant_release got=%b want=%b", obs(), 5'b00000);
    end
  endtask

  task automatic test_settle_path();
    logic [4:0] want [3];
    want[0] = 5'b10001; want[1] = 5'b10001; want[2] = 5'b11011;
    apply_reset();
    req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== want[i] || obs() !== mexp()) begin
        errors++; $display("FAIL settle_path cyc=%0d got=%b want=%b", i, obs(), want[i]);
      end
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_alternating();
    int p, pos;
    logic [4:0] want;
    logic prev_sel;
    p = 2 * (MAX_HOLD + SETTLE_CYC);
    apply_reset();
    req0 = 1'b1; req1 = 1'b1;
    prev_sel = sel;
    for (int k = 1; k <= 3 * p; k++) begin
      step();
      pos = (k - 1) % p;
      if (pos < MAX_HOLD)                        want = 5'b01101;
      else if (pos < MAX_HOLD + SETTLE_CYC)      want = 5'b10001;
      else if (pos < 2 * MAX_HOLD + SETTLE_CYC)  want = 5'b11011;
      else                                       want = 5'b00001;
      checks++;
      if (obs() !== want || obs() !== mexp()) begin
        errors++; $display("FAIL alternating k=%0d got=%b want=%b", k, obs(), want);
      end
      checks++;
      if (out_en && sel !== prev_sel) begin
        errors++; $display("FAIL alt_sel_stable k=%0d sel=%b prev=%b", k, sel, prev_sel);
      end
      prev_sel = sel;
    end
  endtask

  task automatic test_settle_abort();
    int n;
    apply_reset();
    req1 = 1'b1;
    repeat (3) step();
    req0 = 1'b1;
    n = 0;
    while (m_bl == 0 && n < 20) begin
      step();
      n++;
      checks++;
      if (obs() !== mexp()) begin
        errors++; $display("FAIL abort_pre cyc=%0d got=%b want=%b", n, obs(), mexp());
      end
    end
    checks++;
    if (n >= 20 || obs() !== 5'b00001) begin
      errors++; $display("FAIL abort_preempt cycles=%0d got=%b want=%b", n, obs(), 5'b00001);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (SETTLE_CYC) step();
    checks++;
    if (obs() !== 5'b00000 || obs() !== mexp()) begin
      errors++; $display("FAIL abort_idle got=%b want=%b", obs(), 5'b00000);
    end
    req1 = 1'b1;
    for (int i = 0; i < SETTLE_CYC + 2; i++) begin
      step();
      checks++;
      if (obs() !== mexp()) begin
        errors++; $display("FAIL abort_reserve cyc=%0d got=%b want=%b", i, obs(), mexp());
      end
    end
  endtask

  task automatic test_async_reset_mid_grant();
    apply_reset();
    req1 = 1'b1;
    repeat (SETTLE_CYC + 3) step();
    checks++;
    if (obs() !== 5'b11011) begin
      errors++; $display("FAIL midgrant_pre got=%b want=%b", obs(), 5'b11011);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 5'b00000) begin
      errors++; $display("FAIL midgrant_reset got=%b want=%b", obs(), 5'b00000);
    end
    apply_reset();
  endtask

  task automatic test_release_at_preempt();
    logic [4:0] want [3];
    want[0] = 5'b00000; want[1] = 5'b10001; want[2] = 5'b10001;
    apply_reset();
    req0 = 1'b1; req1 = 1'b1;
    repeat (MAX_HOLD) step();
    checks++;
    if (obs() !== 5'b01101) begin
      errors++; $display("FAIL relpre_hold got=%b want=%b", obs(), 5'b01101);
    end
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== want[i] || obs() !== mexp()) begin
        errors++; $display("FAIL relpre_seq cyc=%0d got=%b want=%b", i, obs(), want[i]);
      end
    end
    step();
    checks++;
    if (obs() !== 5'b11011 || obs() !== mexp()) begin
      errors++; $display("FAIL relpre_gnt1 got=%b want=%b", obs(), 5'b11011);
    end
  endtask

  task automatic test_random();
    logic prev_sel;
    apply_reset();
    prev_sel = sel;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) req0 = ~req0;
      if ($urandom_range(5) == 0) req1 = ~req1;
      step();
      checks++;
      if (obs() !== mexp()) begin
        errors++; $display("FAIL random cyc=%0d req=%b%b got=%b want=%b", i, req0, req1, obs(), mexp());
      end
      checks++;
      if ((gnt0 && gnt1) || (out_en && sel !== prev_sel)) begin
        errors++; $display("FAIL random_invariant cyc=%0d gnt=%b%b sel=%b prev=%b", i, gnt0, gnt1, sel, prev_sel);
      end
      prev_sel = sel;
    end
  endtask

  initial begin
    test_reset();
    test_direct_grant();
    test_settle_path();
    test_alternating();
    test_settle_abort();
    test_async_reset_mid_grant();
    test_release_at_preempt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
